ula: RTL and testbench
======================

Name: ula

Overview:
- 6-bit, 16-operation arithmetic/logic unit with registered result and status flags (Overflow, Zero).
- Sits in the datapath between operand sources (A, B) and the result bus; Sel comes from control/decode.
- All outputs are registered on the rising clock edge, so results appear one cycle after operands and Sel are applied.

Parameters:
- None. Data width is fixed at 6 bits and select width at 4 bits.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous reset, active-high.
- A  input  6  operand A, two's complement for arithmetic ops.
- B  input  6  operand B, two's complement for arithmetic ops.
- Sel  input  4  operation select.
- O  output  6  registered result.
- Overflow  output  1  registered signed-overflow / shift-out flag.
- Zero  output  1  registered flag; 1 when O == 000000.

Behaviour:
- Clocking: one clock, Clk. Reset is synchronous and active-high.
- Latency: combinational compute from A, B, Sel; registered into O/Overflow/Zero on each rising Clk. Latency is 1 cycle. No handshake; a new operation is accepted every cycle.
- Reset: on a rising edge with Reset=1, O=000000, Overflow=0, Zero=1. Reset overrides any Sel. After Reset deasserts, the next edge captures the current operation.
- Zero is always computed from the new O value in the same edge (Zero == (O==0)), including after reset.
- Operations (Sel -> O; Overflow):
  - 0000 ADD: A+B mod 64. Overflow = signed overflow (A[5]==B[5] and O[5]!=A[5]).
  - 0001 SUB: A−B mod 64. Overflow = signed overflow (A[5]!=B[5] and O[5]!=A[5]).
  - 0010 AND: A&B. Overflow = 0.
  - 0011 OR: A|B. Overflow = 0.
  - 0100 XOR: A^B. Overflow = 0.
  - 0101 NOT: ~A. Overflow = 0.
  - 0110 NAND: ~(A&B). Overflow = 0.
  - 0111 NOR: ~(A|B). Overflow = 0.
  - 1000 XNOR: ~(A^B). Overflow = 0.
  - 1001 SHL: {A[4:0],0}. Overflow = A[5] (bit shifted out).
  - 1010 SHR: {0,A[5:1]}. Overflow = 0.
  - 1011 SAR: {A[5],A[5:1]}. Overflow = 0.
  - 1100 INC: A+1 mod 64. Overflow = 1 only when A=011111.
  - 1101 DEC: A−1 mod 64. Overflow = 1 only when A=100000.
  - 1110 SLT: O=000001 if signed A<B, else 000000. Overflow = 0.
  - 1111 NEG: −A mod 64. Overflow = 1 only when A=100000.
- Boundary cases:
  - Wrap-around is modulo 64 with no saturation.
  - B is ignored for ops 0101, 1001–1101 and 1111.
  - All 16 Sel codes are defined; there is no illegal code.
  - Changes to inputs between edges have no effect on the outputs until the next edge.

Test Plan:
- Reset=1, A=101010, B=010101, Sel=0000, one edge -> O=000000, Overflow=0, Zero=1. Deassert Reset, one edge -> O=111111, Overflow=0, Zero=0.
- ADD A=011111, B=000001 -> O=100000, Overflow=1, Zero=0. ADD A=100000, B=100000 -> O=000000, Overflow=1, Zero=1.
- SUB A=000101, B=000101 -> O=000000, Overflow=0, Zero=1. SUB A=100000, B=000001 -> O=011111, Overflow=1.
- Logic/shift with A=110010, B=101100: AND=100000; NOR=000001; SHL -> O=100100, Overflow=1; SAR=111001; SHR=011001. All except SHL have Overflow=0.
- SLT A=111111 (−1), B=000001 -> O=000001. NEG A=100000 -> O=100000, Overflow=1. INC A=111111 -> O=000000, Zero=1, Overflow=0.
- Sweep 5 random A/B pairs × 16 Sel × Reset∈{0,1}, comparing each against a reference model after one edge. Also check that asserting Reset mid-sequence clears the outputs on that same edge.

Source files
------------

// File: rtl/ula.sv
// ula: 6-bit 16-operation ALU with registered result, overflow and zero flags
module ula (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] A,
    input  logic [5:0] B,
    input  logic [3:0] Sel,
    output logic [5:0] O,
    output logic       Overflow,
    output logic       Zero
);
    logic [5:0] res;
    logic       ov;
    always_comb begin
        res = '0;
        ov  = 1'b0;
        case (Sel)
            4'h0: begin
                res = A + B;
                ov  = (A[5] == B[5]) && (res[5] != A[5]);
            end
            4'h1: begin
                res = A - B;
                ov  = (A[5] != B[5]) && (res[5] != A[5]);
            end
            4'h2: res = A & B;
            4'h3: res = A | B;
            4'h4: res = A ^ B;
            4'h5: res = ~A;
            4'h6: res = ~(A & B);
            4'h7: res = ~(A | B);
            4'h8: res = ~(A ^ B);
            4'h9: begin
                res = {A[4:0], 1'b0};
                ov  = A[5];
            end
            4'hA: res = {1'b0, A[5:1]};
            4'hB: res = {A[5], A[5:1]};
            4'hC: begin
                res = A + 6'd1;
                ov  = (A == 6'b011111);
            end
            4'hD: begin
                res = A - 6'd1;
                ov  = (A == 6'b100000);
            end
            4'hE: res = {5'b0, $signed(A) < $signed(B)};
            default: begin
                res = -A;
                ov  = (A == 6'b100000);
            end
        endcase
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            O        <= '0;
            Overflow <= 1'b0;
            Zero     <= 1'b1;
        end else begin
            O        <= res;
            Overflow <= ov;
            Zero     <= (res == 6'd0);
        end
    end
endmodule

// File: tb/tb_ula.sv
// tb_ula: directed and randomized checks of ula against an integer-arithmetic model
module tb_ula;
    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [5:0] A = '0;
    logic [5:0] B = '0;
    logic [3:0] Sel = '0;
    logic [5:0] O;
    logic       Overflow;
    logic       Zero;
    int passed = 0;
    int total = 0;

    ula dut (
        .Clk(Clk), .Reset(Reset), .A(A), .B(B), .Sel(Sel),
        .O(O), .Overflow(Overflow), .Zero(Zero)
    );

    always #5 Clk = ~Clk;

    // returns {overflow, result}, derived from signed integer arithmetic
    function automatic logic [6:0] model(input logic [5:0] a, input logic [5:0] b, input logic [3:0] s);
        int sa;
        int sb;
        int r;
        logic [5:0] o;
        logic v;
        sa = $signed(a);
        sb = $signed(b);
        r = 0;
        o = '0;
        v = 1'b0;
        case (s)
            4'h0: begin r = sa + sb; o = r[5:0]; v = (r > 31) || (r < -32); end
            4'h1: begin r = sa - sb; o = r[5:0]; v = (r > 31) || (r < -32); end
            4'h2: o = a & b;
            4'h3: o = a | b;
            4'h4: o = a ^ b;
            4'h5: o = ~a;
            4'h6: o = ~(a & b);
            4'h7: o = ~(a | b);
            4'h8: o = ~(a ^ b);
            4'h9: begin r = int'(a) * 2; o = r[5:0]; v = r > 63; end
            4'hA: begin r = int'(a) / 2; o = r[5:0]; end
            4'hB: begin r = (sa < 0) ? (sa - 1) / 2 : sa / 2; o = r[5:0]; end
            4'hC: begin r = sa + 1; o = r[5:0]; v = r > 31; end
            4'hD: begin r = sa - 1; o = r[5:0]; v = r < -32; end
            4'hE: o = (sa < sb) ? 6'd1 : 6'd0;
            default: begin r = -sa; o = r[5:0]; v = r > 31; end
        endcase
        return {v, o};
    endfunction

    task automatic step(input logic r, input logic [5:0] a, input logic [5:0] b, input logic [3:0] s);
        Reset = r;
        A = a;
        B = b;
        Sel = s;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [5:0] oe, input logic ve, input logic ze);
        total++;
        assert (O === oe && Overflow === ve && Zero === ze) passed++;
        else $error("FAIL %s: got O=%b Overflow=%b Zero=%b, expected O=%b Overflow=%b Zero=%b",
                    tag, O, Overflow, Zero, oe, ve, ze);
    endtask

    initial begin
        logic [6:0] e;
        logic [5:0] ra;
        logic [5:0] rb;
        step(1, 6'b101010, 6'b010101, 4'h0); chk("reset", 6'b000000, 0, 1);
        step(0, 6'b101010, 6'b010101, 4'h0); chk("add_after_reset", 6'b111111, 0, 0);
        step(0, 6'b011111, 6'b000001, 4'h0); chk("add_pos_ovf", 6'b100000, 1, 0);
        step(0, 6'b100000, 6'b100000, 4'h0); chk("add_neg_ovf", 6'b000000, 1, 1);
        step(0, 6'b000101, 6'b000101, 4'h1); chk("sub_zero", 6'b000000, 0, 1);
        step(0, 6'b100000, 6'b000001, 4'h1); chk("sub_ovf", 6'b011111, 1, 0);
        step(0, 6'b110010, 6'b101100, 4'h2); chk("and", 6'b100000, 0, 0);
        step(0, 6'b110010, 6'b101100, 4'h7); chk("nor", 6'b000001, 0, 0);
        step(0, 6'b110010, 6'b101100, 4'h9); chk("shl", 6'b100100, 1, 0);
        step(0, 6'b110010, 6'b101100, 4'hB); chk("sar", 6'b111001, 0, 0);
        step(0, 6'b110010, 6'b101100, 4'hA); chk("shr", 6'b011001, 0, 0);
        step(0, 6'b111111, 6'b000001, 4'hE); chk("slt", 6'b000001, 0, 0);
        step(0, 6'b100000, 6'b000000, 4'hF); chk("neg_min", 6'b100000, 1, 0);
        step(0, 6'b111111, 6'b000000, 4'hC); chk("inc_wrap", 6'b000000, 0, 1);
        step(0, 6'b100000, 6'b000000, 4'hD); chk("dec_min", 6'b011111, 1, 0);
        step(0, 6'b011111, 6'b000000, 4'hC); chk("inc_max", 6'b100000, 1, 0);
        A = 6'b000011;
        Sel = 4'h4;
        #3;
        chk("hold_between_edges", 6'b100000, 1, 0);
        for (int p = 0; p < 5; p++) begin
            ra = 6'($urandom);
            rb = 6'($urandom);
            for (int s = 0; s < 16; s++) begin
                e = model(ra, rb, 4'(s));
                step(0, ra, rb, 4'(s));
                chk($sformatf("op%0d_a%b_b%b", s, ra, rb), e[5:0], e[6], e[5:0] == 6'd0);
                step(1, ra, rb, 4'(s));
                chk($sformatf("rst_op%0d", s), 6'b000000, 0, 1);
            end
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
